// File: rtl/mem_arbiter_if.sv
// Shared request type and the cache/memory-side bundle seen by mem_arbiter.
// master = arbiter view; slave = caches plus main memory.
package mem_arbiter_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic [LINE_W-1:0] data;
  } memory_request_t;
endpackage

interface mem_arbiter_if #(
  parameter int LINE_W = mem_arbiter_pkg::LINE_W
);
  logic                             icache_req_valid;
  mem_arbiter_pkg::memory_request_t icache_req_info;
  logic                             icache_rsp_valid;
  logic [LINE_W-1:0]                icache_rsp_data;

  logic                             dcache_req_valid;
  mem_arbiter_pkg::memory_request_t dcache_req_info;
  logic                             dcache_rsp_valid;
  logic [LINE_W-1:0]                dcache_rsp_data;

  logic                             mem_req_valid;
  mem_arbiter_pkg::memory_request_t mem_req_info;
  logic                             mem_rsp_valid;
  logic [LINE_W-1:0]                mem_rsp_data;

  logic                             busy;
  logic                             err_timeout;

  modport master (
    input  icache_req_valid, icache_req_info, dcache_req_valid, dcache_req_info,
    input  mem_rsp_valid, mem_rsp_data,
    output icache_rsp_valid, icache_rsp_data, dcache_rsp_valid, dcache_rsp_data,
    output mem_req_valid, mem_req_info, busy, err_timeout
  );

  modport slave (
    output icache_req_valid, icache_req_info, dcache_req_valid, dcache_req_info,
    output mem_rsp_valid, mem_rsp_data,
    input  icache_rsp_valid, icache_rsp_data, dcache_rsp_valid, dcache_rsp_data,
    input  mem_req_valid, mem_req_info, busy, err_timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin serialiser of icache/dcache line misses onto one memory channel, with response watchdog.
// Latency: grant -> 1-cycle issue -> wait -> 1-cycle resp (3 + memory cycles); requesters hold level until their rsp pulse.
module mem_arbiter #(
  parameter int LINE_W         = mem_arbiter_pkg::LINE_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t                           state_q, state_d;
  logic                             grant_q, grant_d;
  logic                             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             mem_req_valid_q, mem_req_valid_d;
  mem_arbiter_pkg::memory_request_t mem_req_info_q, mem_req_info_d;
  logic                             icache_rsp_valid_q, icache_rsp_valid_d;
  logic                             dcache_rsp_valid_q, dcache_rsp_valid_d;
  logic [LINE_W-1:0]                icache_rsp_data_q, icache_rsp_data_d;
  logic [LINE_W-1:0]                dcache_rsp_data_q, dcache_rsp_data_d;
  logic                             err_timeout_q, err_timeout_d;

  logic              pick;
  logic              rsp_done;
  logic [LINE_W-1:0] rsp_line;

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_grant_d       = last_grant_q;
    cnt_d              = cnt_q;
    mem_req_valid_d    = 1'b0;
    mem_req_info_d     = mem_req_info_q;
    icache_rsp_valid_d = 1'b0;
    dcache_rsp_valid_d = 1'b0;
    icache_rsp_data_d  = icache_rsp_data_q;
    dcache_rsp_data_d  = dcache_rsp_data_q;
    err_timeout_d      = err_timeout_q;
    pick               = GNT_I;
    rsp_done           = 1'b0;
    rsp_line           = '0;

    case (state_q)
      IDLE: begin
        if (bus.icache_req_valid || bus.dcache_req_valid) begin
          // On contention the side that did not win last time gets the slot.
          pick            = (bus.icache_req_valid && bus.dcache_req_valid) ? ~last_grant_q
                                                                          : bus.dcache_req_valid;
          grant_d         = pick;
          last_grant_d    = pick;
          mem_req_info_d  = (pick == GNT_D) ? bus.dcache_req_info : bus.icache_req_info;
          mem_req_valid_d = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A response landing on the deadline cycle still wins over the timeout.
        if (bus.mem_rsp_valid) begin
          rsp_done = 1'b1;
          rsp_line = bus.mem_rsp_data;
        end else if (cnt_q == TMO) begin
          rsp_done      = 1'b1;
          err_timeout_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rsp_done) begin
      state_d = RESP;
      if (grant_q == GNT_D) begin
        dcache_rsp_valid_d = 1'b1;
        dcache_rsp_data_d  = rsp_line;
      end else begin
        icache_rsp_valid_d = 1'b1;
        icache_rsp_data_d  = rsp_line;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      grant_q            <= GNT_I;
      last_grant_q       <= GNT_I;
      cnt_q              <= '0;
      mem_req_valid_q    <= 1'b0;
      mem_req_info_q     <= '0;
      icache_rsp_valid_q <= 1'b0;
      dcache_rsp_valid_q <= 1'b0;
      icache_rsp_data_q  <= '0;
      dcache_rsp_data_q  <= '0;
      err_timeout_q      <= 1'b0;
    end else begin
      state_q            <= state_d;
      grant_q            <= grant_d;
      last_grant_q       <= last_grant_d;
      cnt_q              <= cnt_d;
      mem_req_valid_q    <= mem_req_valid_d;
      mem_req_info_q     <= mem_req_info_d;
      icache_rsp_valid_q <= icache_rsp_valid_d;
      dcache_rsp_valid_q <= dcache_rsp_valid_d;
      icache_rsp_data_q  <= icache_rsp_data_d;
      dcache_rsp_data_q  <= dcache_rsp_data_d;
      err_timeout_q      <= err_timeout_d;
    end
  end

  assign bus.mem_req_valid    = mem_req_valid_q;
  assign bus.mem_req_info     = mem_req_info_q;
  assign bus.icache_rsp_valid = icache_rsp_valid_q;
  assign bus.icache_rsp_data  = icache_rsp_data_q;
  assign bus.dcache_rsp_valid = dcache_rsp_valid_q;
  assign bus.dcache_rsp_data  = dcache_rsp_data_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.err_timeout      = err_timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model predicts grant order, returned data and the sticky error.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LW = 128;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if #(.LINE_W(LW)) bus ();

  mem_arbiter #(.LINE_W(LW), .TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Model state: 1 = dcache, 0 = icache.
  bit              model_last;
  bit              model_err;
  logic [LW-1:0]   model_dat [2];
  memory_request_t exp_req_q [$];
  bit              exp_who_q [$];
  logic [LW-1:0]   exp_dat_q [$];
  bit              exp_to_q  [$];
  int              plan_lat_q[$];
  logic [LW-1:0]   plan_dat_q[$];
  bit              grant_log [$];

  int n_memreq = 0, n_irsp = 0, n_drsp = 0, req_cyc = 0, rsp_cyc = 0;
  memory_request_t last_req;

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic memory_request_t mk(input logic [31:0] a, input logic s, input logic [LW-1:0] d);
    memory_request_t r;
    r.addr = a; r.is_store = s; r.data = d;
    return r;
  endfunction

  function automatic memory_request_t next_info(input memory_request_t i, input int n);
    memory_request_t r;
    r = i;
    for (int k = 0; k < n; k++) begin
      r.addr = r.addr + 32'h40;
      r.data = ~r.data;
    end
    return r;
  endfunction

  function automatic bit model_pick(input bit iv, input bit dv);
    bit who;
    if (iv && dv) who = !model_last;
    else          who = dv;
    model_last = who;
    return who;
  endfunction

  function automatic int pack_log();
    int v;
    v = 0;
    foreach (grant_log[i]) v = (v << 1) | int'(grant_log[i]);
    return v;
  endfunction

  // A response is lost to the watchdog when memory never answers or answers after the 256th wait cycle.
  task automatic expect_txn(input bit who, input memory_request_t info, input int lat, input logic [LW-1:0] mdat);
    bit to;
    to = (lat == 0) || (lat > 256);
    exp_req_q.push_back(info);
    exp_who_q.push_back(who);
    exp_dat_q.push_back(to ? '0 : mdat);
    exp_to_q.push_back(to);
    plan_lat_q.push_back(lat);
    plan_dat_q.push_back(mdat);
  endtask

  task automatic model_reset();
    model_last = 1'b0;
    model_err  = 1'b0;
    model_dat[0] = '0;
    model_dat[1] = '0;
    exp_req_q.delete(); exp_who_q.delete(); exp_dat_q.delete(); exp_to_q.delete();
    plan_lat_q.delete(); plan_dat_q.delete(); grant_log.delete();
  endtask

  task automatic reset_dut();
    @(negedge clock);
    #1 reset = 1'b1;
    bus.icache_req_valid = 1'b0;
    bus.dcache_req_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_req(input bit is_d, input memory_request_t info0, input int n);
    memory_request_t info;
    int t;
    info = info0;
    for (int k = 0; k < n; k++) begin
      if (is_d) begin bus.dcache_req_valid = 1'b1; bus.dcache_req_info = info; end
      else      begin bus.icache_req_valid = 1'b1; bus.icache_req_info = info; end
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!(is_d ? bus.dcache_rsp_valid : bus.icache_rsp_valid) && t < 700);
      if (t >= 700) chk_i("rsp_wait_bound", 0, 1);
      info = next_info(info, 1);
    end
    if (is_d) bus.dcache_req_valid = 1'b0;
    else      bus.icache_req_valid = 1'b0;
    #1;
  endtask

  // Compare process: every cycle out of reset.
  bit            c_who, c_to;
  logic [LW-1:0] c_dat;
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (bus.mem_req_valid) begin
        n_memreq++;
        req_cyc  = cyc;
        last_req = bus.mem_req_info;
        if (exp_req_q.size() == 0) chk_i("unexpected_mem_req", 1, 0);
        else chk_v("mem_req_info", 192'(bus.mem_req_info), 192'(exp_req_q.pop_front()));
      end
      if (bus.icache_rsp_valid || bus.dcache_rsp_valid) begin
        rsp_cyc = cyc;
        n_irsp += int'(bus.icache_rsp_valid);
        n_drsp += int'(bus.dcache_rsp_valid);
        chk_i("rsp_one_hot", int'(bus.icache_rsp_valid && bus.dcache_rsp_valid), 0);
        if (exp_who_q.size() == 0) chk_i("unexpected_rsp", 1, 0);
        else begin
          c_who = exp_who_q.pop_front();
          c_dat = exp_dat_q.pop_front();
          c_to  = exp_to_q.pop_front();
          chk_i("rsp_requester", int'(bus.dcache_rsp_valid), int'(c_who));
          chk_v("rsp_data", 192'(c_who ? bus.dcache_rsp_data : bus.icache_rsp_data), 192'(c_dat));
          chk_v("other_rsp_data_held", 192'(c_who ? bus.icache_rsp_data : bus.dcache_rsp_data),
                192'(model_dat[!c_who]));
          model_dat[c_who] = c_dat;
          if (c_to) model_err = 1'b1;
          grant_log.push_back(c_who);
        end
      end
      chk_i("err_timeout", int'(bus.err_timeout), int'(model_err));
    end
  end

  // Memory: answers each request after its planned latency (0 = never).
  int            rl;
  logic [LW-1:0] rdat;
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = {4{32'hBAD0BAD0}};
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && bus.mem_req_valid) begin
        rl = 0; rdat = '0;
        if (plan_lat_q.size() != 0) begin
          rl   = plan_lat_q.pop_front();
          rdat = plan_dat_q.pop_front();
        end
        if (rl > 0) begin
          fork
            begin
              automatic int            l  = rl;
              automatic logic [LW-1:0] dd = rdat;
              repeat (l) @(negedge clock);
              bus.mem_rsp_valid = 1'b1;
              bus.mem_rsp_data  = dd;
              @(negedge clock);
              bus.mem_rsp_valid = 1'b0;
            end
          join_none
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, t, base_m, base_i, base_d, ci, cd;
    bit w0, w1, w;
    memory_request_t ri, rd;

    reset = 1'b0;
    bus.icache_req_valid = 1'b0; bus.icache_req_info = '0;
    bus.dcache_req_valid = 1'b0; bus.dcache_req_info = '0;
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #1;

    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_mem_req_valid", int'(bus.mem_req_valid), 0);
    chk_v("rst_mem_req_info", 192'(bus.mem_req_info), 192'(0));
    chk_i("rst_i_rsp_valid", int'(bus.icache_rsp_valid), 0);
    chk_i("rst_d_rsp_valid", int'(bus.dcache_rsp_valid), 0);
    chk_v("rst_i_rsp_data", 192'(bus.icache_rsp_data), 192'(0));
    chk_v("rst_d_rsp_data", 192'(bus.dcache_rsp_data), 192'(0));
    chk_i("rst_err", int'(bus.err_timeout), 0);

    // Single dcache load, memory answers 4 cycles after the request pulse.
    base_m = n_memreq; base_i = n_irsp; base_d = n_drsp;
    rd = mk(32'h1000, 1'b0, '0);
    expect_txn(model_pick(1'b0, 1'b1), rd, 4, {4{32'hDEADBEEF}});
    @(negedge clock); a = cyc;
    run_req(1'b1, rd, 1);
    chk_i("t1_req_lat", req_cyc - a, 1);
    chk_i("t1_rsp_lat", rsp_cyc - req_cyc, 5);
    chk_v("t1_req_addr", 192'(last_req.addr), 192'(32'h1000));
    chk_v("t1_rsp_data", 192'(bus.dcache_rsp_data), 192'({4{32'hDEADBEEF}}));
    chk_i("t1_mem_req_pulses", n_memreq - base_m, 1);
    chk_i("t1_i_rsp_pulses", n_irsp - base_i, 0);
    chk_i("t1_d_rsp_pulses", n_drsp - base_d, 1);
    chk_i("t1_busy_resp", int'(bus.busy), 1);
    @(negedge clock); #1;
    chk_i("t1_busy_idle", int'(bus.busy), 0);

    // Both request together right after reset: dcache first.
    reset_dut();
    ri = mk(32'h2100, 1'b0, '0);
    rd = mk(32'h2200, 1'b0, '0);
    w0 = model_pick(1'b1, 1'b1);
    expect_txn(w0, w0 ? rd : ri, 3, {4{32'h0D0D0D0D}});
    w1 = model_pick(w0, !w0);
    expect_txn(w1, w1 ? rd : ri, 5, {4{32'h1C1C1C1C}});
    base_m = n_memreq;
    @(negedge clock);
    fork
      run_req(1'b0, ri, 1);
      run_req(1'b1, rd, 1);
    join
    chk_i("t2_mem_req_pulses", n_memreq - base_m, 2);
    chk_i("t2_grants", grant_log.size(), 2);
    chk_i("t2_order", pack_log(), 2);
    chk_v("t2_d_data", 192'(bus.dcache_rsp_data), 192'({4{32'h0D0D0D0D}}));
    chk_v("t2_i_data", 192'(bus.icache_rsp_data), 192'({4{32'h1C1C1C1C}}));

    // Continuous contention for six transactions.
    grant_log.delete();
    ri = mk(32'h3100, 1'b0, {4{32'h11112222}});
    rd = mk(32'h3200, 1'b0, {4{32'h33334444}});
    ci = 0; cd = 0;
    for (int k = 0; k < 6; k++) begin
      w = model_pick(1'b1, k < 5);
      if (w) begin expect_txn(w, next_info(rd, cd), 2 + k, {4{32'h600D0000 | 32'(k)}}); cd++; end
      else   begin expect_txn(w, next_info(ri, ci), 2 + k, {4{32'h600D0000 | 32'(k)}}); ci++; end
    end
    @(negedge clock);
    fork
      run_req(1'b0, ri, 3);
      run_req(1'b1, rd, 3);
    join
    chk_i("t3_grants", grant_log.size(), 6);
    chk_i("t3_order", pack_log(), 42);

    // dcache store with an ack.
    rd = mk(32'h2000, 1'b1, {16{8'hA5}});
    expect_txn(model_pick(1'b0, 1'b1), rd, 6, 128'h0123456789ABCDEF_FEDCBA9876543210);
    @(negedge clock);
    run_req(1'b1, rd, 1);
    chk_i("t4_is_store", int'(last_req.is_store), 1);
    chk_v("t4_store_data", 192'(last_req.data), 192'({16{8'hA5}}));
    chk_v("t4_store_addr", 192'(last_req.addr), 192'(32'h2000));
    chk_v("t4_ack_data", 192'(bus.dcache_rsp_data), 192'(128'h0123456789ABCDEF_FEDCBA9876543210));
    chk_i("t4_err", int'(bus.err_timeout), 0);

    // Memory never answers: watchdog fires.
    ri = mk(32'h5000, 1'b0, '0);
    expect_txn(model_pick(1'b1, 1'b0), ri, 0, {4{32'hFFFFFFFF}});
    @(negedge clock);
    run_req(1'b0, ri, 1);
    chk_i("t5_rsp_lat", rsp_cyc - req_cyc, 257);
    chk_v("t5_rsp_data", 192'(bus.icache_rsp_data), 192'(0));
    chk_i("t5_err", int'(bus.err_timeout), 1);
    @(negedge clock); #1;
    chk_i("t5_idle_after", int'(bus.busy), 0);
    repeat (5) @(negedge clock); #1;
    chk_i("t5_err_sticky", int'(bus.err_timeout), 1);

    // Response lands exactly on the deadline cycle.
    reset_dut();
    rd = mk(32'h6000, 1'b0, '0);
    expect_txn(model_pick(1'b0, 1'b1), rd, 256, {4{32'hCAFEF00D}});
    @(negedge clock);
    run_req(1'b1, rd, 1);
    chk_i("t6_rsp_lat", rsp_cyc - req_cyc, 257);
    chk_i("t6_err", int'(bus.err_timeout), 0);
    chk_v("t6_rsp_data", 192'(bus.dcache_rsp_data), 192'({4{32'hCAFEF00D}}));

    // Reset during WAIT; the late memory pulse must be ignored.
    reset_dut();
    rd = mk(32'h7000, 1'b0, '0);
    expect_txn(model_pick(1'b0, 1'b1), rd, 20, {4{32'h77777777}});
    base_m = n_memreq; base_i = n_irsp; base_d = n_drsp;
    @(negedge clock);
    bus.dcache_req_valid = 1'b1;
    bus.dcache_req_info  = rd;
    t = 0;
    do begin
      @(negedge clock); #1;
      t++;
    end while (n_memreq == base_m && t < 50);
    chk_i("t7_issued", n_memreq - base_m, 1);
    repeat (5) @(negedge clock); #1;
    chk_i("t7_busy_wait", int'(bus.busy), 1);
    reset_dut();
    repeat (25) @(negedge clock); #1;
    chk_i("t7_busy", int'(bus.busy), 0);
    chk_i("t7_mem_req_valid", int'(bus.mem_req_valid), 0);
    chk_v("t7_mem_req_info", 192'(bus.mem_req_info), 192'(0));
    chk_i("t7_i_rsp_valid", int'(bus.icache_rsp_valid), 0);
    chk_i("t7_d_rsp_valid", int'(bus.dcache_rsp_valid), 0);
    chk_v("t7_i_rsp_data", 192'(bus.icache_rsp_data), 192'(0));
    chk_v("t7_d_rsp_data", 192'(bus.dcache_rsp_data), 192'(0));
    chk_i("t7_err", int'(bus.err_timeout), 0);
    chk_i("t7_no_rsp", (n_irsp - base_i) + (n_drsp - base_d), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the data cache and the instruction cache miss ports, and upstream of main memory.
- Accepts line-miss requests (loads/fills and evictions/stores) from both caches and serialises them onto a single memory request channel.
- Routes each memory response back to the requester that issued it.
- Round-robin arbitration with a response timeout watchdog.

Parameters:
- LINE_W, 128, cache line width in bits (equals `DCACHE_LINE_WIDTH and the icache line width).
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for mem_rsp_valid before a timeout is declared.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- icache_req_valid  in  1  icache miss request pending (level)
- icache_req_info  in  memory_request_t  icache request: addr, is_store, data[LINE_W]
- icache_rsp_valid  out  1  one-cycle response pulse to icache
- icache_rsp_data  out  LINE_W  line returned to icache
- dcache_req_valid  in  1  dcache miss/evict request pending (level)
- dcache_req_info  in  memory_request_t  dcache request
- dcache_rsp_valid  out  1  one-cycle response pulse to dcache
- dcache_rsp_data  out  LINE_W  line returned to dcache
- mem_req_valid  out  1  one-cycle request pulse to memory
- mem_req_info  out  memory_request_t  latched granted request
- mem_rsp_valid  in  1  memory response/ack pulse
- mem_rsp_data  in  LINE_W  memory line data
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (async, active-high): state = IDLE.
- Reset values: all rsp_valid = 0, all rsp_data = 0, mem_req_valid = 0, mem_req_info = 0, busy = 0, err_timeout = 0, timeout counter = 0.
- Reset values (cont.): last_grant = ICACHE, so dcache wins the first conflict.
- Reset mid-transaction abandons the transaction; no response is issued and any late mem_rsp_valid arriving in IDLE is ignored.
- Requester contract:
  - Hold req_valid and req_info stable until the requester's rsp_valid pulse.
  - Deassert req_valid no later than the cycle after the pulse.
  - The arbiter samples req_info only at grant.
- FSM states:
  - IDLE: if exactly one valid, grant it. If both are valid, grant the one that is not last_grant. On grant, latch req_info into mem_req_info, record grant and last_grant, go to ISSUE. With no valid, stay.
  - ISSUE (1 cycle): mem_req_valid = 1 registered, asserted exactly this one cycle. Clear counter. Go to WAIT.
  - WAIT: counter increments each cycle (saturating). On mem_rsp_valid, latch mem_rsp_data into the granted requester's rsp_data, go to RESP.
  - WAIT timeout: if counter == TIMEOUT_CYCLES with no response, set err_timeout, load rsp_data = 0 for the granted requester, go to RESP.
  - RESP (1 cycle): the granted requester's rsp_valid = 1; the other requester's stays 0. Go to IDLE.
- mem_rsp_valid in WAIT on the same cycle the counter reaches TIMEOUT_CYCLES counts as a normal response; no error.
- Store requests (is_store = 1): same flow. Memory response is an ack. rsp_data carries mem_rsp_data unchanged.
- The non-granted rsp_data register holds its previous value.
- mem_rsp_valid outside WAIT is ignored.
- Minimum latency, req_valid high to rsp_valid: 3 cycles plus memory latency (IDLE grant → ISSUE → WAIT ≥1 → RESP).
- Back-to-back: the earliest new grant is in IDLE the cycle after RESP.
- A requester still valid then is re-served only if it is the sole requester. A still-valid requester is a contract violation and is not checked.
- Starvation: under continuous contention, grants strictly alternate I/D.

Test Plan:
- Single dcache load, addr 0x1000, memory responds 4 cycles after mem_req_valid with 0xDEADBEEF_... -> mem_req_valid one cycle with addr 0x1000; dcache_rsp_valid pulses once with that data; icache_rsp_valid stays 0.
- Both valid in the same cycle after reset -> dcache granted first, icache second; exactly two mem_req_valid pulses; each response returns to the correct requester.
- Both held valid continuously for 6 transactions -> grant order D,I,D,I,D,I.
- dcache store, is_store = 1, data 0xA5..A5 -> mem_req_info matches exactly; mem ack -> dcache_rsp_valid pulse; err_timeout = 0.
- Timeout: no mem_rsp_valid for 255 cycles in WAIT -> err_timeout rises and stays 1; requester gets rsp_valid with data 0; FSM in IDLE next cycle.
- Timeout boundary: mem_rsp_valid exactly on cycle 255 -> normal response, err_timeout = 0.
- Reset asserted during WAIT, then mem_rsp_valid arrives after release -> no rsp_valid, busy = 0, all outputs at reset values.
